uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  16x-oversampled UART receiver (8N1, LSB first) with byte FIFO, for the host
//  serial link. Replaces single-sample RX path: start-bit validation, mid-bit
//  sampling, framing/overrun detection, buffered bytes for the consumer logic.
// PARAMETERS
//  OVS_DIV   651  fclk cycles per oversample tick (100 MHz / (9600*16))
//  FIFO_AW   3    FIFO address width; depth = 2**FIFO_AW = 8 bytes
// PORTS
//  fclk        in   1          system clock, all logic on posedge
//  rst         in   1          asynchronous, active-low reset
//  rx          in   1          async serial line, idle high
//  rd_en       in   1          pop head byte (ignored when rd_valid=0)
//  rd_data     out  8          FIFO head byte (first-word-fall-through)
//  rd_valid    out  1          FIFO not empty
//  fifo_count  out  FIFO_AW+1  bytes held, 0..2**FIFO_AW
//  rx_busy     out  1          frame in progress (state != IDLE)
//  frame_err   out  1          1-cycle pulse: stop bit sampled low
//  overrun     out  1          1-cycle pulse: good byte dropped, FIFO full
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0; rd_data 8'h00; sync flops 1; state IDLE;
//   tick counter 0; FIFO pointers/count 0; armed=1. Reset mid-frame discards it.
//  Sync: rx through 2 flops -> rx_s; all decisions use rx_s only.
//  Tick: free-running counter 0..OVS_DIV-1; tick=1 for one fclk when ==OVS_DIV-1.
//  FSM advances only on tick; scnt = 4-bit oversample count, bcnt = bit index.
//   IDLE : armed=1 if rx_s=1; if armed & rx_s=0 -> START, scnt=0.
//   START: scnt++; at scnt==7 (mid start bit): rx_s=0 -> DATA, scnt=0, bcnt=0;
//          rx_s=1 -> IDLE (glitch rejected, no flag).
//   DATA : scnt++; at scnt==15 sample rx_s, shift right into sr[7] (LSB first),
//          scnt=0; after bcnt==7 -> STOP, else bcnt++.
//   STOP : at scnt==15 sample rx_s:
//          1 -> push sr if FIFO not full (or pop same cycle), else overrun=1;
//          0 -> frame_err=1, byte discarded, armed=0 (waits for line high).
//          Either way -> IDLE.
//  Push lands on fclk edge of the STOP-sample tick; rd_valid/fifo_count
//   update that same edge (visible next cycle).
//  FIFO: circular, FIFO_AW-bit wrap pointers, separate count.
//   rd_data = mem[rd_ptr] when rd_valid=1, else 8'h00.
//   Pop when rd_en & rd_valid; rd_ptr++ (wraps 2**FIFO_AW-1 -> 0).
//   Push+pop same cycle: both done, count unchanged (also when full).
//   Push when full w/o pop: dropped, overrun pulse, FIFO contents untouched.
//  rx_busy = (state != IDLE). frame_err/overrun never both high together.
//  Baud mismatch tolerance: +/- ~3% (mid-bit sample, 1/16 bit quantisation).
// TESTING (bench uses OVS_DIV=4 -> 64 fclk per bit)
//  Send 8'hA5 8N1 -> one push, rd_data=8'hA5, rd_valid=1, fifo_count=1, no flags.
//  Send 8'h00 with stop bit low, line held low 3 bits then high -> frame_err
//   pulse once, fifo_count=0, no new frame until rx returns high.
//  20-fclk low glitch on idle line -> back to IDLE, fifo_count=0, no flags.
//  Send 9 bytes 8'h01..8'h09, rd_en=0 -> fifo_count=8, overrun pulse on 9th;
//   then pop 8 -> 8'h01..8'h08 in order, rd_valid=0, rd_data=8'h00.
//  FIFO full, assert rd_en on the push cycle of next byte -> count stays 8,
//   no overrun, new byte last out.
//  Assert rst low at DATA bit 4 of 8'h3C -> outputs 0, FIFO empty; next full
//   8'h5A frame received correctly.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Receive-side bundle of the UART RX FIFO: serial line in, consumer read port
// and status/flag outputs.
interface uart_rx_fifo_if #(
  parameter int FIFO_AW = 3
);
  logic               rx;
  logic               rd_en;
  logic [7:0]         rd_data;
  logic               rd_valid;
  logic [FIFO_AW:0]   fifo_count;
  logic               rx_busy;
  logic               frame_err;
  logic               overrun;

  // Drives the line and the read strobe, observes everything else.
  modport master (
    output rx, rd_en,
    input  rd_data, rd_valid, fifo_count, rx_busy, frame_err, overrun
  );

  // The receiver itself.
  modport slave (
    input  rx, rd_en,
    output rd_data, rd_valid, fifo_count, rx_busy, frame_err, overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 16x-oversampled 8N1 UART receiver with start-bit validation, mid-bit sampling,
// framing/overrun flags and a first-word-fall-through byte FIFO.
module uart_rx_fifo #(
  parameter int OVS_DIV = 651,
  parameter int FIFO_AW = 3
) (
  input  logic           fclk,
  input  logic           rst,
  uart_rx_fifo_if.slave  bus
);

  localparam int                 DIV_W    = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
  localparam int                 DEPTH    = 1 << FIFO_AW;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(OVS_DIV - 1);
  localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic               rx_meta_q, rx_meta_d;
  logic               rx_s_q, rx_s_d;
  logic [DIV_W-1:0]   div_q, div_d;
  state_e             state_q, state_d;
  logic [3:0]         scnt_q, scnt_d;
  logic [2:0]         bcnt_q, bcnt_d;
  logic [7:0]         sr_q, sr_d;
  logic               armed_q, armed_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               frame_err_q, frame_err_d;
  logic               overrun_q, overrun_d;
  logic [7:0]         mem_q [DEPTH];

  logic tick, push_req, stop_bad;
  logic rd_valid, full, pop, push, drop;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    rx_meta_d = bus.rx;
    rx_s_d    = rx_meta_q;
    tick      = (div_q == DIV_LAST);
    div_d     = tick ? '0 : div_q + 1'b1;
  end

  // Receive FSM: only moves on oversample ticks, decisions use rx_s_q only.
  always_comb begin
    state_d  = state_q;
    scnt_d   = scnt_q;
    bcnt_d   = bcnt_q;
    sr_d     = sr_q;
    armed_d  = armed_q;
    push_req = 1'b0;
    stop_bad = 1'b0;
    if (tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (rx_s_q) armed_d = 1'b1;
          if (armed_q && !rx_s_q) begin
            state_d = S_START;
            scnt_d  = '0;
          end
        end
        S_START: begin
          if (scnt_q == 4'd7) begin
            if (!rx_s_q) begin
              state_d = S_DATA;
              scnt_d  = '0;
              bcnt_d  = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            scnt_d = scnt_q + 4'd1;
          end
        end
        S_DATA: begin
          if (scnt_q == 4'd15) begin
            sr_d   = {rx_s_q, sr_q[7:1]};
            scnt_d = '0;
            if (bcnt_q == 3'd7) state_d = S_STOP;
            else                bcnt_d  = bcnt_q + 3'd1;
          end else begin
            scnt_d = scnt_q + 4'd1;
          end
        end
        S_STOP: begin
          if (scnt_q == 4'd15) begin
            state_d = S_IDLE;
            scnt_d  = '0;
            if (rx_s_q) begin
              push_req = 1'b1;
            end else begin
              stop_bad = 1'b1;
              armed_d  = 1'b0;   // a broken frame must see the line high before re-arming
            end
          end else begin
            scnt_d = scnt_q + 4'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FIFO bookkeeping: a pop frees the slot a same-cycle push needs.
  always_comb begin
    rd_valid    = (count_q != '0);
    full        = (count_q == FULL_CNT);
    pop         = bus.rd_en && rd_valid;
    push        = push_req && (!full || pop);
    drop        = push_req && full && !pop;
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d     = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    frame_err_d = stop_bad;
    overrun_d   = drop;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge fclk or negedge rst) begin
    if (!rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      div_q       <= '0;
      state_q     <= S_IDLE;
      scnt_q      <= '0;
      bcnt_q      <= '0;
      sr_q        <= '0;
      armed_q     <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      div_q       <= div_d;
      state_q     <= state_d;
      scnt_q      <= scnt_d;
      bcnt_q      <= bcnt_d;
      sr_q        <= sr_d;
      armed_q     <= armed_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // NOTE: the storage array is not reset; the pointers and count alone define its valid contents.
  always_ff @(posedge fclk) begin
    if (push) mem_q[wr_ptr_q] <= sr_q;
  end

  assign bus.rd_data    = rd_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign bus.rd_valid   = rd_valid;
  assign bus.fifo_count = count_q;
  assign bus.rx_busy    = (state_q != S_IDLE);
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised scoreboard bench for uart_rx_fifo: frames are driven bit by bit,
// a queue model predicts FIFO contents and flag events, a monitor checks them.
module tb_uart_rx_fifo;

  localparam int OVS_DIV = 4;
  localparam int FIFO_AW = 3;
  localparam int DEPTH   = 1 << FIFO_AW;
  localparam int BIT_CYC = 16 * OVS_DIV;
  // Ticks from START entry to the stop-bit sample: 8 (half start) + 8*16 + 16.
  localparam int PUSH_CYC = (8 + 8 * 16 + 16) * OVS_DIV;

  typedef enum int {EV_FERR = 1, EV_OVR = 2} ev_e;

  logic fclk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [7:0] model_q [$];
  ev_e        ev_q [$];

  uart_rx_fifo_if #(.FIFO_AW(FIFO_AW)) ifc ();

  uart_rx_fifo #(.OVS_DIV(OVS_DIV), .FIFO_AW(FIFO_AW)) dut (
    .fclk (fclk),
    .rst  (rst),
    .bus  (ifc)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Advance n rising edges, then step just past the edge so inputs change away from it.
  task automatic cyc(input int n);
    repeat (n) @(posedge fclk);
    #1;
  endtask

  // The model decides the outcome of a frame from the contents it predicts at arrival.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit with_pop);
    if (!stop_ok)                                  ev_q.push_back(EV_FERR);
    else if (model_q.size() < DEPTH || with_pop)   model_q.push_back(d);
    else                                           ev_q.push_back(EV_OVR);
    ifc.rx = 1'b0;
    cyc(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      ifc.rx = d[i];
      cyc(BIT_CYC);
    end
    ifc.rx = stop_ok;
    cyc(BIT_CYC);
  endtask

  task automatic pop_one();
    if (model_q.size() > 0) begin
      ifc.rd_en = 1'b1;
      cyc(1);
      ifc.rd_en = 1'b0;
    end
  endtask

  task automatic drain();
    while (model_q.size() > 0) pop_one();
    cyc(2);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " rd_data"},    ifc.rd_data,    0);
    check({tag, " rd_valid"},   ifc.rd_valid,   0);
    check({tag, " fifo_count"}, ifc.fifo_count, 0);
    check({tag, " rx_busy"},    ifc.rx_busy,    0);
    check({tag, " frame_err"},  ifc.frame_err,  0);
    check({tag, " overrun"},    ifc.overrun,    0);
  endtask

  task automatic check_state(input string tag);
    check({tag, " count"},  ifc.fifo_count, model_q.size());
    check({tag, " events"}, ev_q.size(),    0);
  endtask

  // Raise rd_en for exactly the edge on which the in-flight frame is pushed.
  task automatic pop_at_push();
    int waited = 0;
    while (!ifc.rx_busy && waited < 50) begin
      cyc(1);
      waited++;
    end
    check("busy rise before push+pop", ifc.rx_busy, 1);
    if (ifc.rx_busy) begin
      cyc(PUSH_CYC - 1);
      ifc.rd_en = 1'b1;
      cyc(1);
      ifc.rd_en = 1'b0;
    end
  endtask

  // Monitor: compares every pop and every flag pulse against the model.
  always @(negedge fclk) begin
    if (rst) begin
      if (ifc.rd_en && ifc.rd_valid) begin
        check("pop expected", model_q.size() > 0, 1);
        if (model_q.size() > 0) check("pop data", ifc.rd_data, model_q.pop_front());
      end
      if (ifc.frame_err || ifc.overrun) begin
        check("flags exclusive", ifc.frame_err && ifc.overrun, 0);
        check("flag pending", ev_q.size() > 0, 1);
        if (ev_q.size() > 0) check("flag kind", ifc.overrun ? EV_OVR : EV_FERR, ev_q.pop_front());
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] v;
    bit         seen_busy;

    rst       = 1'b0;
    ifc.rx    = 1'b1;
    ifc.rd_en = 1'b0;
    #1;
    check_quiet("reset");
    cyc(5);
    rst = 1'b1;
    cyc(20);
    check_quiet("after reset");

    // Single good byte.
    send_frame(8'hA5, 1'b1, 1'b0);
    cyc(4);
    check_state("A5");
    check("A5 rd_valid", ifc.rd_valid, 1);
    check("A5 rd_data",  ifc.rd_data,  8'hA5);
    drain();

    // Stop bit low, line held low for three more bit times.
    send_frame(8'h00, 1'b0, 1'b0);
    seen_busy = 1'b0;
    for (int i = 0; i < 3 * BIT_CYC; i++) begin
      cyc(1);
      if (ifc.rx_busy) seen_busy = 1'b1;
    end
    check("ferr no rearm while low", seen_busy, 0);
    check_state("ferr");
    ifc.rx = 1'b1;
    cyc(BIT_CYC);

    // Short low glitch on an idle line.
    ifc.rx    = 1'b0;
    seen_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (ifc.rx_busy) seen_busy = 1'b1;
    end
    ifc.rx = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cyc(1);
      if (ifc.rx_busy) seen_busy = 1'b1;
    end
    check("glitch entered start", seen_busy, 1);
    check("glitch back to idle",  ifc.rx_busy, 0);
    check_state("glitch");

    // Nine bytes without reading: eight stored, ninth overruns.
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 1'b0);
    cyc(4);
    check_state("fill 9");
    check("fill head", ifc.rd_data, 8'h01);
    drain();
    check("drained rd_valid", ifc.rd_valid, 0);
    check("drained rd_data",  ifc.rd_data,  8'h00);

    // Full FIFO, pop on the push edge of one more byte.
    for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 1'b1, 1'b0);
    v = 8'($urandom);
    fork
      send_frame(v, 1'b1, 1'b1);
      pop_at_push();
    join
    cyc(4);
    check_state("push+pop full");
    check("push+pop newest last", model_q[model_q.size() - 1], v);
    drain();

    // Reset in the middle of data bit 4.
    send_frame(8'h77, 1'b1, 1'b0);
    cyc(4);
    check_state("pre-reset");
    v = 8'h3C;
    ifc.rx = 1'b0;
    cyc(BIT_CYC);
    for (int i = 0; i < 4; i++) begin
      ifc.rx = v[i];
      cyc(BIT_CYC);
    end
    ifc.rx = v[4];
    cyc(BIT_CYC / 2);
    check("mid-frame busy", ifc.rx_busy, 1);
    rst = 1'b0;
    #1;
    check_quiet("async reset");
    model_q.delete();
    cyc(3);
    ifc.rx = 1'b1;
    rst    = 1'b1;
    cyc(100);
    check_quiet("post reset");
    send_frame(8'h5A, 1'b1, 1'b0);
    cyc(4);
    check_state("5A");
    check("5A rd_data", ifc.rd_data, 8'h5A);
    drain();

    // Random traffic with occasional framing errors and sporadic reads.
    for (int n = 0; n < 25; n++) begin
      cyc($urandom_range(0, 40));
      v = 8'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        send_frame(v, 1'b0, 1'b0);
        cyc(BIT_CYC / 2);
        ifc.rx = 1'b1;
        cyc(BIT_CYC);
      end else begin
        send_frame(v, 1'b1, 1'b0);
      end
      cyc(4);
      check_state("random");
      if ($urandom_range(0, 2) == 0) begin
        for (int k = $urandom_range(1, 3); k > 0; k--) pop_one();
      end
    end
    drain();
    check_state("final");
    check("final model empty", model_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
